// File: rtl/idx_free_list_pkg.sv
// Shared constants for the index free-list slice.
//   PICK_LOW  : grant the lowest-numbered free index.
//   PICK_HIGH : grant the highest-numbered free index.
package idx_free_list_pkg;
  localparam logic PICK_LOW  = 1'b0;
  localparam logic PICK_HIGH = 1'b1;
endpackage

// File: rtl/idx_lzc.sv
// Priority pick over a bit vector (leading/trailing-zero count utility).
// Ports:
//   vec    in   WIDTH      candidate bits
//   idx    out  IDX_WIDTH  position of the first set bit in MODE order (0 when empty)
//   empty  out  1          no bit of vec is set
module idx_lzc
  import idx_free_list_pkg::*;
#(
  parameter int   WIDTH     = 16,
  parameter logic MODE      = PICK_LOW,
  parameter int   IDX_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 empty
);

  // Scan away from the preferred end so the last hit is the winning bit.
  always_comb begin
    idx   = '0;
    empty = ~(|vec);
    if (MODE == PICK_HIGH) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx = IDX_WIDTH'(i);
        end else begin
          idx = idx;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = IDX_WIDTH'(i);
        end else begin
          idx = idx;
        end
      end
    end
  end

endmodule

// File: rtl/idx_onehot_dec.sv
// Index-to-one-hot decoder.
// Ports:
//   idx          in   IDX_WIDTH  index to decode
//   onehot       out  WIDTH      one-hot mask, all zero when idx is out of range
//   out_of_range out  1          idx >= WIDTH (only possible when WIDTH is not a power of two)
module idx_onehot_dec #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = $clog2(WIDTH)
) (
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [WIDTH-1:0]     onehot,
  output logic                 out_of_range
);

  logic [31:0] idx_ext;
  assign idx_ext = 32'(idx);

  // Decode the index one bit position at a time.
  always_comb begin
    onehot       = '0;
    out_of_range = (idx_ext >= 32'(WIDTH));
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = (idx_ext == 32'(i));
    end
  end

endmodule

// File: rtl/idx_free_list.sv
// Bitmap free-list: grants the first free index (lowest or highest by MODE)
// and accepts index releases on FREE_PORTS ports. Illegal releases are
// dropped and latch a sticky error flag.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   alloc_req    consumer takes alloc_idx this cycle
//   alloc_ready  at least one entry is free
//   alloc_idx    index granted when alloc_req & alloc_ready
//   free_en      per-port release valid
//   free_idx     per-port released index, port p at [p*IDX_WIDTH +: IDX_WIDTH]
//   flush        return every entry to free
//   free_cnt     registered count of free entries
//   err_o        sticky protocol-error flag
module idx_free_list
  import idx_free_list_pkg::*;
#(
  parameter int   WIDTH      = 16,
  parameter int   FREE_PORTS = 2,
  parameter logic MODE       = PICK_LOW,
  parameter int   IDX_WIDTH  = $clog2(WIDTH),
  parameter int   CNT_WIDTH  = $clog2(WIDTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc_req,
  output logic                            alloc_ready,
  output logic [IDX_WIDTH-1:0]            alloc_idx,
  input  logic [FREE_PORTS-1:0]           free_en,
  input  logic [FREE_PORTS*IDX_WIDTH-1:0] free_idx,
  input  logic                            flush,
  output logic [CNT_WIDTH-1:0]            free_cnt,
  output logic                            err_o
);

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CNT_WIDTH'(v[i]);
    end
    return c;
  endfunction

  logic [WIDTH-1:0] bitmap;       // 1 = free
  logic [WIDTH-1:0] bitmap_next;
  logic             pick_empty;
  logic             alloc_fire;
  logic [WIDTH-1:0] alloc_mask;
  logic             alloc_oor;
  logic [WIDTH-1:0] alloc_onehot;
  logic [WIDTH-1:0] port_mask [FREE_PORTS];
  logic [FREE_PORTS-1:0] port_oor;
  logic [WIDTH-1:0] legal_mask;
  logic             err_now;

  idx_lzc #(.WIDTH(WIDTH), .MODE(MODE), .IDX_WIDTH(IDX_WIDTH)) u_pick (
    .vec   (bitmap),
    .idx   (alloc_idx),
    .empty (pick_empty)
  );

  assign alloc_ready = ~pick_empty;
  assign alloc_fire  = alloc_req & alloc_ready;

  idx_onehot_dec #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_alloc_dec (
    .idx          (alloc_idx),
    .onehot       (alloc_mask),
    .out_of_range (alloc_oor)
  );

  // The picker never yields an out-of-range index; the guard only keeps the mask clean.
  assign alloc_onehot = (alloc_fire & ~alloc_oor) ? alloc_mask : '0;

  for (genvar p = 0; p < FREE_PORTS; p++) begin : g_port
    idx_onehot_dec #(.WIDTH(WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_dec (
      .idx          (free_idx[p*IDX_WIDTH +: IDX_WIDTH]),
      .onehot       (port_mask[p]),
      .out_of_range (port_oor[p])
    );
  end

  // Screen each release; lower ports claim an index first, so a duplicate
  // on a higher port is the one flagged and dropped.
  always_comb begin
    legal_mask = '0;
    err_now    = 1'b0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      if (!free_en[p]) begin
        err_now = err_now;
      end else if (port_oor[p]) begin
        err_now = 1'b1;
      end else if (|(port_mask[p] & bitmap)) begin
        err_now = 1'b1;                       // already free
      end else if (|(port_mask[p] & alloc_onehot)) begin
        err_now = 1'b1;                       // collides with this cycle's grant
      end else if (|(port_mask[p] & legal_mask)) begin
        err_now = 1'b1;                       // same index on two ports
      end else begin
        legal_mask = legal_mask | port_mask[p];
      end
    end
  end

  // Next bitmap; flush overrides allocation and release.
  always_comb begin
    if (flush) begin
      bitmap_next = '1;
    end else begin
      bitmap_next = (bitmap & ~alloc_onehot) | legal_mask;
    end
  end

  // State registers; the count is recomputed from the next bitmap so it cannot drift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap   <= '1;
      free_cnt <= CNT_WIDTH'(WIDTH);
      err_o    <= 1'b0;
    end else begin
      bitmap   <= bitmap_next;
      free_cnt <= popcount(bitmap_next);
      err_o    <= err_o | (err_now & ~flush);
    end
  end

endmodule

// File: tb/tb_idx_free_list.sv
module tb_idx_free_list;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_req = 1'b0;
  logic [1:0] free_en = 2'b00;
  logic [7:0] free_idx = 8'h00;
  logic       flush = 1'b0;

  logic       rdy0, err0, rdy1, err1;
  logic [3:0] idx0, idx1;
  logic [4:0] cnt0;
  logic [3:0] cnt1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  idx_free_list #(.WIDTH(16), .FREE_PORTS(2), .MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ready(rdy0), .alloc_idx(idx0),
    .free_en(free_en), .free_idx(free_idx), .flush(flush), .free_cnt(cnt0), .err_o(err0)
  );

  idx_free_list #(.WIDTH(12), .FREE_PORTS(2), .MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ready(rdy1), .alloc_idx(idx1),
    .free_en(free_en), .free_idx(free_idx), .flush(flush), .free_cnt(cnt1), .err_o(err1)
  );

  // Reference model: per-entry free flags for each instance.
  int mw[2] = '{16, 12};
  int mhigh[2] = '{0, 1};
  int mfree[2][16];
  int merr[2];

  function automatic int m_pick(int d);
    int r;
    r = -1;
    for (int i = 0; i < mw[d]; i++) begin
      if (mfree[d][i] != 0 && (r < 0 || mhigh[d] != 0)) r = i;
    end
    return r;
  endfunction

  function automatic int m_count(int d);
    int c;
    c = 0;
    for (int i = 0; i < mw[d]; i++) c += mfree[d][i];
    return c;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mfree[d][i] = (i < mw[d]) ? 1 : 0;
      merr[d] = 0;
    end
  endtask

  task automatic m_step(input logic req, input logic [1:0] fen, input int a, input int b, input logic fl);
    int g, ix;
    int nf[16];
    int taken[16];
    for (int d = 0; d < 2; d++) begin
      if (fl) begin
        for (int i = 0; i < mw[d]; i++) mfree[d][i] = 1;
      end else begin
        g = m_pick(d);
        for (int i = 0; i < 16; i++) begin nf[i] = mfree[d][i]; taken[i] = 0; end
        if (req && g >= 0) nf[g] = 0;
        for (int p = 0; p < 2; p++) begin
          if (fen[p]) begin
            ix = (p == 0) ? a : b;
            if (ix >= mw[d]) merr[d] = 1;
            else if (mfree[d][ix] != 0) merr[d] = 1;
            else if (req && g == ix) merr[d] = 1;
            else if (taken[ix] != 0) merr[d] = 1;
            else begin taken[ix] = 1; nf[ix] = 1; end
          end
        end
        for (int i = 0; i < 16; i++) mfree[d][i] = nf[i];
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("m0_ready", int'(rdy0), (m_pick(0) >= 0) ? 1 : 0);
    if (m_pick(0) >= 0) chk("m0_idx", int'(idx0), m_pick(0));
    chk("m0_cnt", int'(cnt0), m_count(0));
    chk("m0_err", int'(err0), merr[0]);
    chk("m1_ready", int'(rdy1), (m_pick(1) >= 0) ? 1 : 0);
    if (m_pick(1) >= 0) chk("m1_idx", int'(idx1), m_pick(1));
    chk("m1_cnt", int'(cnt1), m_count(1));
    chk("m1_err", int'(err1), merr[1]);
  endtask

  // Called just after a rising edge; checks after the next one.
  task automatic step(input logic req, input logic [1:0] fen, input logic [3:0] a, input logic [3:0] b, input logic fl);
    alloc_req = req; free_en = fen; free_idx = {b, a}; flush = fl;
    m_step(req, fen, int'(a), int'(b), fl);
    @(posedge clk); #1;
    alloc_req = 1'b0; free_en = 2'b00; flush = 1'b0;
    check_model();
  endtask

  // Asynchronous reset checked before any clock edge can occur.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_cnt0", int'(cnt0), 16);
    chk("rst_idx0", int'(idx0), 0);
    chk("rst_err0", int'(err0), 0);
    check_model();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       req;
    logic [1:0] fen;
    logic [3:0] i0;
    logic [3:0] i1;
    logic       fl;
    logic       ready;
    logic [3:0] idx;
    int         cnt;
    logic       err;
  } vec_t;

  vec_t tbl[5];

  function automatic int pick_used();
    int s;
    s = $urandom_range(0, 15);
    for (int k = 0; k < 16; k++) begin
      if (mfree[0][(s + k) % 16] == 0) return (s + k) % 16;
    end
    return s;
  endfunction

  initial begin
    // Starting from full allocation of dut0 (W=16, low-first).
    tbl[0] = '{req:1'b0, fen:2'b11, i0:4'd5, i1:4'd9, fl:1'b0, ready:1'b1, idx:4'd5, cnt:2, err:1'b0};
    tbl[1] = '{req:1'b1, fen:2'b00, i0:4'd0, i1:4'd0, fl:1'b0, ready:1'b1, idx:4'd9, cnt:1, err:1'b0};
    tbl[2] = '{req:1'b1, fen:2'b00, i0:4'd0, i1:4'd0, fl:1'b0, ready:1'b0, idx:4'd0, cnt:0, err:1'b0};
    tbl[3] = '{req:1'b0, fen:2'b01, i0:4'd3, i1:4'd0, fl:1'b0, ready:1'b1, idx:4'd3, cnt:1, err:1'b0};
    tbl[4] = '{req:1'b1, fen:2'b10, i0:4'd0, i1:4'd3, fl:1'b0, ready:1'b0, idx:4'd0, cnt:0, err:1'b1};

    @(posedge clk); #1;
    do_reset();
    chk("reset_ready0", int'(rdy0), 1);
    chk("reset_idx1_high", int'(idx1), 11);

    // Sixteen back-to-back grants.
    for (int k = 0; k < 16; k++) begin
      chk("seq_idx", int'(idx0), k);
      chk("seq_ready", int'(rdy0), 1);
      step(1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
      chk("seq_cnt", int'(cnt0), 15 - k);
    end
    chk("full_ready", int'(rdy0), 0);
    chk("full_err", int'(err0), 0);

    for (int v = 0; v < 5; v++) begin
      step(tbl[v].req, tbl[v].fen, tbl[v].i0, tbl[v].i1, tbl[v].fl);
      chk("tbl_ready", int'(rdy0), int'(tbl[v].ready));
      if (tbl[v].ready) chk("tbl_idx", int'(idx0), int'(tbl[v].idx));
      chk("tbl_cnt", int'(cnt0), tbl[v].cnt);
      chk("tbl_err", int'(err0), int'(tbl[v].err));
    end
    chk("tbl_high_err1", int'(err1), 1);

    // Same index on both ports: counted once, flagged.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
    step(1'b0, 2'b11, 4'd7, 4'd7, 1'b0);
    chk("dup_cnt", int'(cnt0), 9);
    chk("dup_err", int'(err0), 1);

    // Out-of-range release on the 12-entry instance.
    do_reset();
    step(1'b0, 2'b01, 4'd13, 4'd0, 1'b0);
    chk("oor_err1", int'(err1), 1);
    chk("oor_cnt1", int'(cnt1), 12);

    // Flush wins over alloc and a bad release, raises nothing, keeps a set error.
    do_reset();
    step(1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
    step(1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
    step(1'b1, 2'b01, 4'd15, 4'd0, 1'b1);
    chk("flush_cnt", int'(cnt0), 16);
    chk("flush_err", int'(err0), 0);
    chk("flush_idx", int'(idx0), 0);
    step(1'b0, 2'b01, 4'd15, 4'd0, 1'b0);
    step(1'b0, 2'b00, 4'd0, 4'd0, 1'b1);
    chk("flush_keep_err", int'(err0), 1);

    // Reset in the middle of a run: error set, four entries free.
    do_reset();
    step(1'b0, 2'b01, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
    chk("mid_cnt_before", int'(cnt0), 4);
    chk("mid_err_before", int'(err0), 1);
    do_reset();

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic       r, fl;
      logic [1:0] fe;
      logic [3:0] a, b;
      if (n % 60 == 59) do_reset();
      r  = 1'($urandom_range(0, 1));
      fe = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) != 0) ? 4'(pick_used()) : 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) != 0) ? 4'(pick_used()) : 4'($urandom_range(0, 15));
      fl = ($urandom_range(0, 40) == 0);
      step(r, fe, a, b, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
